// File: rtl/spawn_position_ctrl_if.sv
// Spawn offer channel between the spawn controller (master) and the object manager (slave).
interface spawn_position_ctrl_if #(
  parameter int X_BITS = 11,
  parameter int Y_BITS = 11
);
  logic              spawn_valid;
  logic              spawn_ack;
  logic [X_BITS-1:0] spawn_x;
  logic [Y_BITS-1:0] spawn_y;
  logic              spawn_fail;
  logic [2:0]        tries_used;

  modport master (
    output spawn_valid, spawn_x, spawn_y, spawn_fail, tries_used,
    input  spawn_ack
  );

  modport slave (
    input  spawn_valid, spawn_x, spawn_y, spawn_fail, tries_used,
    output spawn_ack
  );
endinterface

// File: rtl/spawn_position_ctrl.sv
// Frame-paced spawn position picker: strobes the X/Y random generators, rejects candidates
// outside the playfield or near the player, and offers the first good one over valid/ack.
module spawn_position_ctrl #(
  parameter int X_BITS       = 11,
  parameter int Y_BITS       = 11,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 607,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 447,
  parameter int SAFE_RADIUS  = 64,
  parameter int SPAWN_PERIOD = 60,
  parameter int MAX_TRIES    = 4
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              startOfFrame,
  input  logic              enable,
  input  logic [X_BITS-1:0] rand_x,
  input  logic [Y_BITS-1:0] rand_y,
  input  logic [X_BITS-1:0] player_x,
  input  logic [Y_BITS-1:0] player_y,
  output logic              rise,
  spawn_position_ctrl_if.master spawn
);

  localparam int FW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  typedef enum logic [2:0] {IDLE, WAIT, REQ, SETTLE, CHECK, OFFER} state_t;

  state_t            state, state_next;
  logic [FW-1:0]     frame_cnt, frame_next;
  logic [2:0]        try_cnt, try_next, tries_inc;
  logic [2:0]        tries_q, tries_used_next;
  logic              valid_q, valid_next;
  logic              fail_q, fail_next;
  logic              rise_next;
  logic [X_BITS-1:0] x_q, x_next;
  logic [Y_BITS-1:0] y_q, y_next;

  logic [X_BITS:0]   dx;
  logic [Y_BITS:0]   dy;
  logic              in_range, in_safe, accept;

  // Distances are taken one bit wider so the subtraction can never wrap.
  always_comb begin
    dx = (rand_x >= player_x) ? ({1'b0, rand_x} - {1'b0, player_x})
                              : ({1'b0, player_x} - {1'b0, rand_x});
    dy = (rand_y >= player_y) ? ({1'b0, rand_y} - {1'b0, player_y})
                              : ({1'b0, player_y} - {1'b0, rand_y});
    in_range = (int'(rand_x) >= X_MIN) && (int'(rand_x) <= X_MAX) &&
               (int'(rand_y) >= Y_MIN) && (int'(rand_y) <= Y_MAX);
    in_safe  = (int'(dx) < SAFE_RADIUS) && (int'(dy) < SAFE_RADIUS);
    accept   = in_range && !in_safe;
  end

  always_comb begin
    state_next      = state;
    frame_next      = frame_cnt;
    try_next        = try_cnt;
    tries_inc       = try_cnt + 3'd1;
    valid_next      = valid_q;
    x_next          = x_q;
    y_next          = y_q;
    fail_next       = 1'b0;
    tries_used_next = tries_q;
    rise_next       = 1'b0;

    case (state)
      IDLE: begin
        if (enable) begin
          state_next = WAIT;
          frame_next = '0;
        end
      end
      WAIT: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (startOfFrame) begin
          if (frame_cnt == FW'(SPAWN_PERIOD - 1)) begin
            frame_next = '0;
            try_next   = '0;
            state_next = REQ;
          end else begin
            frame_next = frame_cnt + 1'b1;
          end
        end
      end
      REQ:    state_next = enable ? SETTLE : IDLE;
      SETTLE: state_next = enable ? CHECK : IDLE;
      CHECK: begin
        if (!enable) begin
          state_next = IDLE;
        end else begin
          try_next = tries_inc;
          if (accept) begin
            x_next          = rand_x;
            y_next          = rand_y;
            valid_next      = 1'b1;
            tries_used_next = tries_inc;
            state_next      = OFFER;
          end else if (tries_inc == 3'(MAX_TRIES)) begin
            fail_next       = 1'b1;
            tries_used_next = 3'(MAX_TRIES);
            state_next      = WAIT;
          end else begin
            state_next = REQ;
          end
        end
      end
      // Enable is deliberately not checked here; the offer must complete first.
      OFFER: begin
        if (spawn.spawn_ack) begin
          valid_next = 1'b0;
          state_next = WAIT;
        end
      end
      default: state_next = IDLE;
    endcase

    rise_next = (state_next == REQ);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      frame_cnt <= '0;
      try_cnt   <= '0;
      rise      <= 1'b0;
      valid_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      fail_q    <= 1'b0;
      tries_q   <= '0;
    end else begin
      state     <= state_next;
      frame_cnt <= frame_next;
      try_cnt   <= try_next;
      rise      <= rise_next;
      valid_q   <= valid_next;
      x_q       <= x_next;
      y_q       <= y_next;
      fail_q    <= fail_next;
      tries_q   <= tries_used_next;
    end
  end

  assign spawn.spawn_valid = valid_q;
  assign spawn.spawn_x     = x_q;
  assign spawn.spawn_y     = y_q;
  assign spawn.spawn_fail  = fail_q;
  assign spawn.tries_used  = tries_q;

endmodule

// File: tb/tb_spawn_position_ctrl.sv
// Scoreboard bench for spawn_position_ctrl: directed candidates feed a latched generator model,
// expected offers/failures are queued and matched by an independent negedge monitor.
module tb_spawn_position_ctrl;

  logic        clk = 1'b0;
  logic        resetN;
  logic        sof;
  logic        enable;
  logic [10:0] rand_x, rand_y, player_x, player_y;
  logic        rise;

  spawn_position_ctrl_if #(.X_BITS(11), .Y_BITS(11)) bus ();

  spawn_position_ctrl #(
    .X_BITS(11), .Y_BITS(11),
    .X_MIN(0), .X_MAX(607), .Y_MIN(0), .Y_MAX(447),
    .SAFE_RADIUS(64), .SPAWN_PERIOD(3), .MAX_TRIES(4)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(sof),
    .enable(enable),
    .rand_x(rand_x),
    .rand_y(rand_y),
    .player_x(player_x),
    .player_y(player_y),
    .rise(rise),
    .spawn(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_fail;
    int x;
    int y;
    int tries;
  } exp_t;

  exp_t exp_q[$];
  int   gen_x_q[$];
  int   gen_y_q[$];
  int   total = 0;
  int   bad = 0;
  int   rise_count = 0;

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input int px, input int py);
    player_x = 11'(px);
    player_y = 11'(py);
  endtask

  task automatic add_candidate(input int cx, input int cy);
    gen_x_q.push_back(cx);
    gen_y_q.push_back(cy);
  endtask

  task automatic expect_offer(input int ex, input int ey, input int et);
    exp_t e;
    e.is_fail = 1'b0; e.x = ex; e.y = ey; e.tries = et;
    exp_q.push_back(e);
  endtask

  task automatic expect_fail(input int et);
    exp_t e;
    e.is_fail = 1'b1; e.x = 0; e.y = 0; e.tries = et;
    exp_q.push_back(e);
  endtask

  task automatic tick_frame();
    @(negedge clk);
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
  endtask

  // Three frame ticks; only the third may start an attempt.
  task automatic run_period(input string tag);
    for (int i = 0; i < 2; i++) begin
      repeat (2) @(negedge clk);
      tick_frame();
      check_output({tag, " no early rise"}, int'(rise), 0);
    end
    repeat (2) @(negedge clk);
    tick_frame();
    check_output({tag, " rise after period"}, int'(rise), 1);
  endtask

  task automatic wait_offer(input string tag, output int lat);
    lat = 1;
    while (!bus.spawn_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check_output({tag, " offer seen"}, int'(bus.spawn_valid), 1);
  endtask

  task automatic ack_offer(input string tag);
    @(negedge clk);
    bus.spawn_ack = 1'b1;
    @(negedge clk);
    bus.spawn_ack = 1'b0;
    check_output({tag, " valid drops after ack"}, int'(bus.spawn_valid), 0);
  endtask

  // Latched generator model: a new value appears after each rise strobe.
  always @(negedge clk) begin
    if (resetN && rise && gen_x_q.size() > 0) begin
      rand_x = 11'(gen_x_q.pop_front());
      rand_y = 11'(gen_y_q.pop_front());
    end
  end

  // Rise shape monitor: single-cycle pulses, at least two low cycles between them.
  int  low_run = 0, high_run = 0;
  bit  rise_prev = 1'b0, seen_rise = 1'b0;
  always @(negedge clk) begin
    if (!resetN) begin
      rise_prev = 1'b0; seen_rise = 1'b0; low_run = 0; high_run = 0;
    end else begin
      if (rise) begin
        if (!rise_prev) begin
          if (seen_rise) check_output("rise low gap >= 2", int'(low_run >= 2), 1);
          rise_count++;
          high_run = 0;
        end
        high_run++;
        seen_rise = 1'b1;
        low_run = 0;
      end else begin
        if (rise_prev) check_output("rise width", high_run, 1);
        low_run++;
      end
      rise_prev = rise;
    end
  end

  // Scoreboard monitor: every new offer or failure pulse consumes one expectation.
  bit valid_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!resetN) begin
      valid_prev = 1'b0;
    end else begin
      if (bus.spawn_valid && !valid_prev) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected offer", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_output("offer kind", 0, int'(e.is_fail));
          check_output("spawn_x", int'(bus.spawn_x), e.x);
          check_output("spawn_y", int'(bus.spawn_y), e.y);
          check_output("offer tries_used", int'(bus.tries_used), e.tries);
        end
      end
      if (bus.spawn_fail) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected spawn_fail", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_output("fail kind", 1, int'(e.is_fail));
          check_output("fail tries_used", int'(bus.tries_used), e.tries);
        end
      end
      valid_prev = bus.spawn_valid;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    resetN = 1'b0; enable = 1'b0; sof = 1'b0; bus.spawn_ack = 1'b0;
    rand_x = '0; rand_y = '0; player_x = '0; player_y = '0;
    repeat (2) @(negedge clk);
    check_output("reset rise", int'(rise), 0);
    check_output("reset valid", int'(bus.spawn_valid), 0);
    check_output("reset spawn_x", int'(bus.spawn_x), 0);
    check_output("reset spawn_y", int'(bus.spawn_y), 0);
    check_output("reset fail", int'(bus.spawn_fail), 0);
    check_output("reset tries_used", int'(bus.tries_used), 0);
    resetN = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    $display("[TB] first-try accept");
    apply_stimulus(400, 300);
    add_candidate(100, 100);
    expect_offer(100, 100, 1);
    run_period("t1");
    @(negedge clk);
    check_output("t1 rise one cycle", int'(rise), 0);
    wait_offer("t1", lat);
    check_output("t1 latency", lat, 3);

    $display("[TB] offer held without ack");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("t2 valid held", int'(bus.spawn_valid), 1);
      check_output("t2 x held", int'(bus.spawn_x), 100);
      check_output("t2 y held", int'(bus.spawn_y), 100);
    end
    ack_offer("t2");

    $display("[TB] all tries inside safe box");
    apply_stimulus(100, 100);
    for (int i = 0; i < 4; i++) add_candidate(130, 90);
    expect_fail(4);
    rise_count = 0;
    run_period("t3");
    lat = 1;
    while (!bus.spawn_fail && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check_output("t3 fail seen", int'(bus.spawn_fail), 1);
    check_output("t3 rise count", rise_count, 4);
    check_output("t3 valid stays low", int'(bus.spawn_valid), 0);
    @(negedge clk);
    check_output("t3 fail one cycle", int'(bus.spawn_fail), 0);

    $display("[TB] out of range then accept");
    apply_stimulus(400, 300);
    add_candidate(700, 100);
    add_candidate(50, 50);
    expect_offer(50, 50, 2);
    run_period("t4");
    wait_offer("t4", lat);
    ack_offer("t4");

    $display("[TB] X_MAX edge");
    add_candidate(607, 100);
    expect_offer(607, 100, 1);
    run_period("t5");
    wait_offer("t5", lat);
    ack_offer("t5");

    $display("[TB] safe box edge");
    apply_stimulus(100, 100);
    add_candidate(163, 100);
    add_candidate(164, 100);
    expect_offer(164, 100, 2);
    run_period("t6");
    wait_offer("t6", lat);
    ack_offer("t6");

    $display("[TB] enable dropped in SETTLE");
    apply_stimulus(400, 300);
    add_candidate(300, 300);
    run_period("t7");
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check_output("t7 rise low", int'(rise), 0);
    check_output("t7 valid low", int'(bus.spawn_valid), 0);
    check_output("t7 no fail", int'(bus.spawn_fail), 0);
    tick_frame();
    tick_frame();
    check_output("t7 idle ignores ticks", int'(rise), 0);
    enable = 1'b1;
    @(negedge clk);
    add_candidate(200, 200);
    expect_offer(200, 200, 1);
    run_period("t7b");
    wait_offer("t7b", lat);

    $display("[TB] async reset during offer");
    #1 resetN = 1'b0;
    #1;
    check_output("t8 valid async", int'(bus.spawn_valid), 0);
    check_output("t8 rise async", int'(rise), 0);
    check_output("t8 tries async", int'(bus.tries_used), 0);
    @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);
    check_output("scoreboard drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spawn_position_ctrl.md
Name: spawn_position_ctrl

Overview:
- Consumes the outputs of two free-running latched random generators (X and Y): drives their shared `rise` strobe and samples their `dout` values.
- Accepts a candidate spawn position only if it is inside the playfield and outside a safe box around the player.
- Retries up to MAX_TRIES times, then offers the accepted position to the object manager over a valid/ack handshake.
- Paced by frame ticks, so one spawn attempt runs every SPAWN_PERIOD frames.

Parameters:
- X_BITS, 11, width of the X coordinate (matches the X generator SIZE_BITS)
- Y_BITS, 11, width of the Y coordinate
- X_MIN, 0, lowest legal spawn X
- X_MAX, 607, highest legal spawn X
- Y_MIN, 0, lowest legal spawn Y
- Y_MAX, 447, highest legal spawn Y
- SAFE_RADIUS, 64, half-size of the exclusion box around the player
- SPAWN_PERIOD, 60, frames between spawn attempts (must be ≥1)
- MAX_TRIES, 4, candidates evaluated per attempt before giving up (must be ≥1)

Ports:
- clk  in  1  system clock
- resetN  in  1  reset
- startOfFrame  in  1  one-cycle frame tick
- enable  in  1  spawning enabled (game running)
- rand_x  in  X_BITS  X generator dout
- rand_y  in  Y_BITS  Y generator dout
- player_x  in  X_BITS  player top-left X
- player_y  in  Y_BITS  player top-left Y
- spawn_ack  in  1  consumer accepts the offered position
- rise  out  1  strobe to both generators' `rise` inputs
- spawn_valid  out  1  position offer pending
- spawn_x  out  X_BITS  offered X
- spawn_y  out  Y_BITS  offered Y
- spawn_fail  out  1  one-cycle pulse: all tries rejected
- tries_used  out  3  candidates consumed in the last completed attempt

Behaviour:
- **Reset and clock:** reset resetN, asynchronous, active-low; clock clk.
- **Reset values:** state=IDLE; rise=0; spawn_valid=0; spawn_x=0; spawn_y=0; spawn_fail=0; tries_used=0; frame counter=0; try counter=0.
- **Output registration:** all outputs are registered.
- **IDLE:** when enable=1, go to WAIT and clear the frame counter.
- **WAIT:** increment the frame counter on each startOfFrame.
  - On the startOfFrame where counter == SPAWN_PERIOD-1: clear the counter, clear the try counter, go to REQ.
  - enable=0 returns to IDLE.
- **REQ (1 cycle):** rise=1; go to SETTLE.
- **SETTLE (1 cycle):** rise=0. The generators latch dout on the edge that sees rise high, so rand_x/rand_y are stable from the next cycle onward. Go to CHECK.
- **CHECK (1 cycle):** rise=0; increment the try counter.
  - Reject the candidate if rand_x<X_MIN, rand_x>X_MAX, rand_y<Y_MIN, or rand_y>Y_MAX.
  - Also reject if |rand_x−player_x| < SAFE_RADIUS AND |rand_y−player_y| < SAFE_RADIUS.
  - Compute both absolute differences unsigned, one bit wider than the operands; no wrap is allowed.
  - Accept: latch spawn_x/spawn_y, set spawn_valid=1 and tries_used=try count, go to OFFER.
  - Reject with tries < MAX_TRIES: go to REQ. This guarantees rise is low for ≥2 cycles between strobes.
  - Reject with tries == MAX_TRIES: pulse spawn_fail for 1 cycle, set tries_used=MAX_TRIES, go to WAIT.
- **OFFER:** spawn_valid, spawn_x and spawn_y stay stable until the cycle spawn_ack=1 is sampled.
  - On that edge spawn_valid drops and the state goes to WAIT.
  - spawn_ack outside OFFER is ignored.
  - enable=0 does not abort OFFER; it is seen on return to WAIT.
- **enable=0 in REQ/SETTLE/CHECK:** abort to IDLE, force rise=0, no spawn_fail pulse.
- **Frame ticks outside WAIT/IDLE:** ignored; the counter does not advance.
- **Minimum latency:** from the triggering startOfFrame to spawn_valid, first-try accept, is 4 clocks (WAIT→REQ→SETTLE→CHECK→OFFER).
- **Player position:** player_x/player_y are sampled in CHECK only.
- **Asynchronous reset mid-OFFER:** spawn_valid drops immediately; no ack is required.

Test Plan:
- SPAWN_PERIOD=3, enable=1, rand_x=100, rand_y=100, player=(400,300) → rise is a one-cycle pulse 1 clk after the 3rd startOfFrame; spawn_valid=1 with spawn=(100,100) 4 clks after that tick; tries_used=1.
- Hold spawn_ack=0 for 10 clks, then pulse it → spawn_valid and spawn_x/y stay stable for 10 clks; spawn_valid drops the clock after ack; the next attempt starts exactly 3 frames later.
- player=(100,100) with rand=(130,90) on every try, MAX_TRIES=4 → 4 rise pulses, each separated by ≥2 low cycles; spawn_fail one-cycle pulse; tries_used=4; spawn_valid stays 0.
- rand=(700,100) on try 1, then (50,50) on try 2 → rejected as out of range, then accepted; spawn=(50,50); tries_used=2. Edge checks: rand_x=607 is accepted; |dx|=64 with |dy|=0 is accepted.
- Drop enable during SETTLE → rise=0, state IDLE, no spawn_fail pulse. Raise enable again → the frame counter restarts from 0.
- Assert resetN=0 asynchronously during OFFER → spawn_valid=0, rise=0, tries_used=0 immediately, without waiting for a clock edge.
